// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the REDUX-V multi-cycle instruction sequencer:
// state encodings and the bit positions of the control_unit signals vector.
package instr_sequencer_pkg;

    localparam int STATE_W = 3;

    // State encodings; 6 and 7 are illegal and recover to IDLE.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    // Bit positions inside the control_unit signals vector.
    localparam int SIG_BR  = 0;   // conditional branch on zero
    localparam int SIG_J   = 1;   // unconditional jump
    localparam int SIG_RA  = 2;   // register-address operand select
    localparam int SIG_RE  = 3;   // register-file write-back
    localparam int SIG_DM  = 4;   // data memory access
    localparam int SIG_WE  = 5;   // memory write
    localparam int SIG_SE  = 6;   // sign extend immediate
    localparam int SIG_SP  = 7;   // stack-pointer operation
    localparam int SIG_SPR = 8;   // stack read (POP) versus write (PUSH)

    // True when the decoded instruction needs a data-memory cycle.
    function automatic logic needs_mem(input logic [9:0] sig);
        needs_mem = sig[SIG_DM] | sig[SIG_WE];
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Shares one memory port
// between instruction fetch and data access and generates the PC, IR,
// register-file and stack-pointer strobes from the latched decode vector.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int OP    = 4,
    parameter int SIG_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt,
    input  logic [OP-1:0]    op,
    input  logic [SIG_W-1:0] signals,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_we,
    output logic             sp_inc,
    output logic             sp_dec,
    output logic             retire,
    output logic [2:0]       state
);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] next_state_s;
    logic [SIG_W-1:0]   sig_q;

    logic mem_req_s, mem_we_s, mem_sel_s, ir_we_s, pc_inc_s, pc_load_s;
    logic reg_we_s, sp_inc_s, sp_dec_s, retire_s;

    // The opcode is trace-only; it is folded here so it is visibly consumed.
    logic unused_s;
    assign unused_s = ^{op, 1'b0};

    // State register: async reset to IDLE, otherwise follow the decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the decode vector when leaving DECODE; later states use only this copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= {SIG_W{1'b0}};
        end else if (state_r == S_DECODE) begin
            sig_q <= signals;
        end else begin
            sig_q <= sig_q;
        end
    end

    // Next-state and strobe decode from state, sig_q, mem_ack and zero.
    always_comb begin
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_sel_s    = 1'b0;
        ir_we_s      = 1'b0;
        pc_inc_s     = 1'b0;
        pc_load_s    = 1'b0;
        reg_we_s     = 1'b0;
        sp_inc_s     = 1'b0;
        sp_dec_s     = 1'b0;
        retire_s     = 1'b0;
        next_state_s = state_r;

        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    ir_we_s      = 1'b1;
                    pc_inc_s     = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                next_state_s = S_EXEC;
            end
            S_EXEC: begin
                if (sig_q[SIG_BR]) begin
                    pc_load_s = zero;
                    retire_s  = 1'b1;
                end else if (sig_q[SIG_J]) begin
                    pc_load_s = 1'b1;
                    retire_s  = 1'b1;
                end else if (needs_mem(sig_q[9:0])) begin
                    // PUSH pre-decrements SP before the store.
                    sp_dec_s     = sig_q[SIG_SP] & ~sig_q[SIG_SPR];
                    next_state_s = S_MEM;
                end else if (sig_q[SIG_RE]) begin
                    next_state_s = S_WB;
                end else begin
                    // NOP, or a decode with no actionable bits: just retire.
                    retire_s = 1'b1;
                end
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                mem_sel_s = 1'b1;
                mem_we_s  = sig_q[SIG_WE];
                if (mem_ack) begin
                    sp_inc_s = sig_q[SIG_SP] & sig_q[SIG_SPR];
                    // PUSH carries RE and WE but must not write back.
                    if (sig_q[SIG_RE] && !sig_q[SIG_WE]) begin
                        next_state_s = S_WB;
                    end else begin
                        retire_s = 1'b1;
                    end
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_we_s = 1'b1;
                retire_s = 1'b1;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase

        // Retire point: halt wins over run.
        if (retire_s) begin
            next_state_s = (halt || !run) ? S_IDLE : S_FETCH;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Outputs forced low while reset is held so mem_req drops immediately.
    assign mem_req = mem_req_s & ~rst;
    assign mem_we  = mem_we_s  & ~rst;
    assign mem_sel = mem_sel_s & ~rst;
    assign ir_we   = ir_we_s   & ~rst;
    assign pc_inc  = pc_inc_s  & ~rst;
    assign pc_load = pc_load_s & ~rst;
    assign reg_we  = reg_we_s  & ~rst;
    assign sp_inc  = sp_inc_s  & ~rst;
    assign sp_dec  = sp_dec_s  & ~rst;
    assign retire  = retire_s  & ~rst;
    assign state   = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst, run, halt, zero, mem_ack;
    logic [3:0] op;
    logic [9:0] signals;
    logic       mem_req, mem_we, mem_sel, ir_we, pc_inc, pc_load;
    logic       reg_we, sp_inc, sp_dec, retire;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [9:0] SIG_ADD  = 10'h008;  // RE
    localparam logic [9:0] SIG_LD   = 10'h018;  // DM | RE
    localparam logic [9:0] SIG_PUSH = 10'h0A8;  // SP | WE | RE
    localparam logic [9:0] SIG_POP  = 10'h198;  // SPR | SP | DM | RE
    localparam logic [9:0] SIG_BRZ  = 10'h001;  // BR
    localparam logic [9:0] SIG_JI   = 10'h002;  // J

    instr_sequencer #(.OP(4), .SIG_W(10)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .op(op),
        .signals(signals), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .ir_we(ir_we), .pc_inc(pc_inc), .pc_load(pc_load),
        .reg_we(reg_we), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt = 1'b0; zero = 1'b0;
        mem_ack = 1'b0; op = 4'd0; signals = 10'd0;
        #3;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        tick(); tick();

        // Reset in the middle of a fetch.
        rst = 1'b0; run = 1'b1;
        tick();
        chk("f_state", {29'd0, state}, 32'd1);
        chk("f_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_mem_sel", {31'd0, mem_sel}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_state", {29'd0, state}, 32'd0);
        mem_ack = 1'b1;
        tick();
        chk("late_ack_state", {29'd0, state}, 32'd0);
        rst = 1'b0; run = 1'b0;
        tick();
        chk("idle_ack_state", {29'd0, state}, 32'd0);
        chk("idle_ir_we", {31'd0, ir_we}, 32'd0);

        // ADD with immediate ack: F D E W.
        run = 1'b1; mem_ack = 1'b1; signals = SIG_ADD;
        tick();
        chk("add_c1_state", {29'd0, state}, 32'd1);
        chk("add_c1_ir_we", {31'd0, ir_we}, 32'd1);
        chk("add_c1_pc_inc", {31'd0, pc_inc}, 32'd1);
        chk("add_c1_pc_load", {31'd0, pc_load}, 32'd0);
        tick();
        chk("add_c2_state", {29'd0, state}, 32'd2);
        chk("add_c2_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("add_c3_state", {29'd0, state}, 32'd3);
        chk("add_c3_retire", {31'd0, retire}, 32'd0);
        tick();
        chk("add_c4_state", {29'd0, state}, 32'd5);
        chk("add_c4_reg_we", {31'd0, reg_we}, 32'd1);
        chk("add_c4_retire", {31'd0, retire}, 32'd1);
        tick();
        chk("add_c5_state", {29'd0, state}, 32'd1);

        // LD with two wait cycles in MEM; signals glitch after DECODE.
        signals = SIG_LD;
        tick();
        chk("ld_d_state", {29'd0, state}, 32'd2);
        tick();
        chk("ld_e_state", {29'd0, state}, 32'd3);
        signals = 10'd0; mem_ack = 1'b0;
        tick();
        chk("ld_m1_state", {29'd0, state}, 32'd4);
        chk("ld_m1_req", {29'd0, mem_req, mem_sel, mem_we}, 32'd6);
        chk("ld_m1_reg_we", {31'd0, reg_we}, 32'd0);
        tick();
        chk("ld_m2_req", {29'd0, mem_req, mem_sel, mem_we}, 32'd6);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("ld_m3_req", {29'd0, mem_req, mem_sel, mem_we}, 32'd6);
        chk("ld_m3_retire", {31'd0, retire}, 32'd0);
        tick();
        chk("ld_w_state", {29'd0, state}, 32'd5);
        chk("ld_w_reg_we", {31'd0, reg_we}, 32'd1);
        chk("ld_w_retire", {31'd0, retire}, 32'd1);
        tick();
        chk("ld_next_state", {29'd0, state}, 32'd1);

        // PUSH: pre-decrement in EXEC, store and retire in MEM.
        signals = SIG_PUSH;
        tick();
        tick();
        chk("push_e_sp_dec", {31'd0, sp_dec}, 32'd1);
        chk("push_e_retire", {31'd0, retire}, 32'd0);
        tick();
        chk("push_m_state", {29'd0, state}, 32'd4);
        chk("push_m_mem_we", {31'd0, mem_we}, 32'd1);
        chk("push_m_retire", {31'd0, retire}, 32'd1);
        chk("push_m_reg_we", {31'd0, reg_we}, 32'd0);
        chk("push_m_sp_inc", {31'd0, sp_inc}, 32'd0);
        tick();
        chk("push_next_state", {29'd0, state}, 32'd1);

        // POP: post-increment on MEM ack, then write back.
        signals = SIG_POP;
        tick();
        tick();
        chk("pop_e_sp_dec", {31'd0, sp_dec}, 32'd0);
        tick();
        chk("pop_m_sp_inc", {31'd0, sp_inc}, 32'd1);
        chk("pop_m_mem_we", {31'd0, mem_we}, 32'd0);
        chk("pop_m_retire", {31'd0, retire}, 32'd0);
        tick();
        chk("pop_w_reg_we", {31'd0, reg_we}, 32'd1);
        chk("pop_w_sp_inc", {31'd0, sp_inc}, 32'd0);
        tick();

        // BRZR taken then not taken.
        signals = SIG_BRZ; zero = 1'b1;
        tick();
        tick();
        chk("brz1_state", {29'd0, state}, 32'd3);
        chk("brz1_pc_load", {31'd0, pc_load}, 32'd1);
        chk("brz1_pc_inc", {31'd0, pc_inc}, 32'd0);
        chk("brz1_retire", {31'd0, retire}, 32'd1);
        chk("brz1_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("brz_next_state", {29'd0, state}, 32'd1);
        zero = 1'b0;
        tick();
        tick();
        chk("brz0_pc_load", {31'd0, pc_load}, 32'd0);
        chk("brz0_retire", {31'd0, retire}, 32'd1);
        tick();

        // JI: unconditional load regardless of zero.
        signals = SIG_JI;
        tick();
        tick();
        chk("ji_pc_load", {31'd0, pc_load}, 32'd1);
        chk("ji_retire", {31'd0, retire}, 32'd1);
        tick();

        // halt raised during EXEC of an ADD.
        signals = SIG_ADD;
        tick();
        tick();
        halt = 1'b1;
        #1;
        chk("halt_e_state", {29'd0, state}, 32'd3);
        tick();
        chk("halt_w_retire", {31'd0, retire}, 32'd1);
        chk("halt_w_reg_we", {31'd0, reg_we}, 32'd1);
        tick();
        chk("halt_idle_state", {29'd0, state}, 32'd0);
        halt = 1'b0;
        tick();
        chk("resume_state", {29'd0, state}, 32'd1);

        // run dropped at retire also returns to IDLE.
        signals = SIG_ADD;
        tick();
        tick();
        run = 1'b0;
        tick();
        tick();
        chk("norun_idle_state", {29'd0, state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the REDUX-V core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driven by the decoded `signals` vector from control_unit.
- It shares the single memory port between instruction fetch and data access, and generates the PC, IR, register-file and SP strobes.
- It sits between control_unit (decode), the register file / ULA datapath and the unified memory.

Parameters:
- OP, 4, opcode width (matches control_unit).
- SIG_W, 10, width of the control_unit `signals` vector.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; allows leaving IDLE and continuing to fetch.
- halt  in  1  level; sampled at retire; forces return to IDLE.
- op  in  OP  opcode field of the current IR (debug/trace only; not used for control).
- signals  in  SIG_W  control_unit decode of `op`; bit positions are the `BR/`J/`RA/`RE/`DM/`WE/`SE/`SP/`SPR macros.
- zero  in  1  flag from register file: branch register == 0.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for mem_req.
- mem_sel  out  1  address mux select: 0 = PC, 1 = data/SP address.
- ir_we  out  1  load IR from memory read data.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= branch/jump target.
- reg_we  out  1  register-file write enable.
- sp_inc  out  1  SP += 1.
- sp_dec  out  1  SP -= 1.
- retire  out  1  one-cycle pulse: instruction complete.
- state  out  3  current state, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Encodings 6 and 7 are illegal and go to IDLE on the next clock.
- Reset: asynchronous; state <= IDLE and sig_q <= 0. All outputs are 0 while rst is high and in IDLE, including mem_req, which drops combinationally mid-request.
- Outputs are decoded from state, sig_q, mem_ack and zero; there is no extra output register.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: mem_req=1, mem_sel=0, mem_we=0. Hold until mem_ack. In the ack cycle: ir_we=1, pc_inc=1, -> DECODE.
- DECODE: exactly one cycle. sig_q <= signals at the clock edge leaving DECODE. All later states use sig_q only, so `signals` may glitch after DECODE.
- EXEC, evaluated in priority order:
  - sig_q[BR]: pc_load=zero, retire=1.
  - sig_q[J]: pc_load=1, retire=1.
  - sig_q[DM] or sig_q[WE]: -> MEM. If sig_q[SP] and !sig_q[SPR] (PUSH), sp_dec=1 here (pre-decrement).
  - sig_q[RE]: -> WB.
  - sig_q == 0: retire=1 (NOP).
- MEM: mem_req=1, mem_sel=1, mem_we=sig_q[WE]. Hold until mem_ack. In the ack cycle:
  - If sig_q[SP] and sig_q[SPR] (POP): sp_inc=1.
  - If sig_q[RE] and !sig_q[WE]: -> WB. Otherwise retire=1.
  - PUSH sets both RE and WE; it retires in MEM and does not write back.
- WB: reg_we=1 for one cycle, retire=1.
- Retire transition: next state = (halt | !run) ? IDLE : FETCH. halt takes priority over run.
- mem_ack outside FETCH/MEM is ignored. mem_req stays high and stable until ack; there is no timeout.
- pc_inc and pc_load are never both high in the same cycle.
- Latency with zero-wait memory:
  - ALU/MOV/ADDI: 4 cycles (F, D, E, W).
  - LD, POP: 5 cycles (F, D, E, M, W).
  - ST, PUSH: 4 cycles (F, D, E, M).
  - BRZR, JI: 3 cycles (F, D, E).
  - Each memory wait cycle adds 1.

Decomposition:
- State encodings `S_IDLE..`S_WB and `STATE_W (3) go in the shared utils.vh, next to the existing `OP and signal-bit macros. No new signal macros are added.
- No sub-module: one state register, one sig_q register and the output decode. control_unit is instantiated by the core top, not inside this block.

Test Plan:
- Reset mid-FETCH: run=1, rst pulses while mem_req=1 -> mem_req=0 in the same cycle, state=0; a late mem_ack=1 is ignored and state stays 0.
- ADD, signals=1<<`RE, ack immediate, run=1 -> state 1,2,3,5; ir_we and pc_inc in cycle 1; reg_we and retire in cycle 4; state=1 in cycle 5.
- LD with memory ack delayed 2 cycles in MEM -> mem_req=1, mem_sel=1, mem_we=0 for 3 cycles; reg_we in the next cycle; total 7 cycles to retire.
- PUSH then POP -> sp_dec=1 in PUSH EXEC and mem_we=1 in MEM, with no reg_we; POP gives sp_inc=1 on its MEM ack, then reg_we.
- BRZR with zero=1 then zero=0 -> pc_load=1, then pc_load=0; retire on the 3rd cycle of each instruction; no mem_req in EXEC.
- halt=1 asserted during EXEC of an ADD -> completes WB and retires, then state=0; clearing halt with run=1 resumes at FETCH the next cycle.
